// File: rtl/id_operand_fetch_pkg.sv
// id_operand_fetch_pkg: widths, NOP encodings and shared structs for the ID operand fetch stage.
package id_operand_fetch_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;
    localparam logic [DATA_W-1:0]   ZERO_WORD  = '0;
    localparam logic [ALUOP_W-1:0]  ALUOP_NOP  = '0;
    localparam logic [ALUSEL_W-1:0] ALUSEL_NOP = '0;
    typedef struct packed {
        logic              wreg;
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] wdata;
    } fwd_t;
    typedef struct packed {
        logic                valid;
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [DATA_W-1:0]   reg1;
        logic [DATA_W-1:0]   reg2;
        logic                wreg;
        logic [ADDR_W-1:0]   wd;
    } idex_t;
endpackage

// File: rtl/id_operand_fetch_if.sv
// id_operand_fetch_if: decoder, regfile, forwarding, control and ID/EX signals of the operand fetch stage.
interface id_operand_fetch_if;
    import id_operand_fetch_pkg::*;
    logic                id_valid, id_re1, id_re2, id_use_imm, id_wreg;
    logic [ADDR_W-1:0]   id_raddr1, id_raddr2, id_wd;
    logic [DATA_W-1:0]   id_imm;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [ALUSEL_W-1:0] id_alusel;
    logic                re1, re2;
    logic [ADDR_W-1:0]   raddr1, raddr2;
    logic [DATA_W-1:0]   rdata1, rdata2;
    logic                ex_fwd_wreg, ex_fwd_is_load, mem_fwd_wreg;
    logic [ADDR_W-1:0]   ex_fwd_wd, mem_fwd_wd;
    logic [DATA_W-1:0]   ex_fwd_wdata, mem_fwd_wdata;
    logic                stall_id, stall_ex, flush, stallreq;
    logic                ex_valid, ex_wreg;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUSEL_W-1:0] ex_alusel;
    logic [DATA_W-1:0]   ex_reg1, ex_reg2;
    logic [ADDR_W-1:0]   ex_wd;
    modport master (
        output id_valid, id_re1, id_re2, id_raddr1, id_raddr2, id_use_imm, id_imm,
               id_aluop, id_alusel, id_wreg, id_wd, rdata1, rdata2,
               ex_fwd_wreg, ex_fwd_wd, ex_fwd_wdata, ex_fwd_is_load,
               mem_fwd_wreg, mem_fwd_wd, mem_fwd_wdata, stall_id, stall_ex, flush,
        input  re1, re2, raddr1, raddr2, stallreq,
               ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wreg, ex_wd
    );
    modport slave (
        input  id_valid, id_re1, id_re2, id_raddr1, id_raddr2, id_use_imm, id_imm,
               id_aluop, id_alusel, id_wreg, id_wd, rdata1, rdata2,
               ex_fwd_wreg, ex_fwd_wd, ex_fwd_wdata, ex_fwd_is_load,
               mem_fwd_wreg, mem_fwd_wd, mem_fwd_wdata, stall_id, stall_ex, flush,
        output re1, re2, raddr1, raddr2, stallreq,
               ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wreg, ex_wd
    );
endinterface

// File: rtl/id_operand_fetch_fwd_mux.sv
// id_operand_fetch_fwd_mux: resolves one source operand from regfile data and the EX/MEM forward paths.
module id_operand_fetch_fwd_mux
    import id_operand_fetch_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    input  fwd_t              ex,
    input  logic              ex_is_load,
    input  fwd_t              mem,
    output logic [DATA_W-1:0] operand,
    output logic              ex_load_hit
);
    logic nz, ex_hit, mem_hit;
    assign nz      = |raddr;
    assign ex_hit  = ex.wreg & (ex.wd == raddr);
    assign mem_hit = mem.wreg & (mem.wd == raddr);
    // A load in EX has no data yet; fall through and let the stall cover it.
    assign operand = !(en && nz)             ? ZERO_WORD :
                     (ex_hit && !ex_is_load) ? ex.wdata  :
                     mem_hit                 ? mem.wdata : rdata;
    assign ex_load_hit = en & nz & ex_hit & ex_is_load;
endmodule

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: ID-stage regfile reader with EX/MEM forwarding, load-use stall and the ID/EX register.
module id_operand_fetch
    import id_operand_fetch_pkg::*;
(
    input logic clk,
    input logic rst,
    id_operand_fetch_if.slave bus
);
    fwd_t              ex_src, mem_src;
    logic [DATA_W-1:0] op1, op2_mux, op2;
    logic              hit1, hit2, stallreq;
    idex_t             d, q;
    assign bus.re1    = bus.id_valid & bus.id_re1;
    assign bus.re2    = bus.id_valid & bus.id_re2 & ~bus.id_use_imm;
    assign bus.raddr1 = bus.id_raddr1;
    assign bus.raddr2 = bus.id_raddr2;
    assign ex_src  = {bus.ex_fwd_wreg, bus.ex_fwd_wd, bus.ex_fwd_wdata};
    assign mem_src = {bus.mem_fwd_wreg, bus.mem_fwd_wd, bus.mem_fwd_wdata};
    id_operand_fetch_fwd_mux u_op1 (
        .en(bus.re1), .raddr(bus.id_raddr1), .rdata(bus.rdata1), .ex(ex_src),
        .ex_is_load(bus.ex_fwd_is_load), .mem(mem_src), .operand(op1), .ex_load_hit(hit1)
    );
    id_operand_fetch_fwd_mux u_op2 (
        .en(bus.re2), .raddr(bus.id_raddr2), .rdata(bus.rdata2), .ex(ex_src),
        .ex_is_load(bus.ex_fwd_is_load), .mem(mem_src), .operand(op2_mux), .ex_load_hit(hit2)
    );
    assign op2      = bus.id_use_imm ? bus.id_imm : op2_mux;
    assign stallreq = ~rst & (hit1 | hit2);
    assign bus.stallreq = stallreq;
    assign d = bus.id_valid ? {1'b1, bus.id_aluop, bus.id_alusel, op1, op2, bus.id_wreg, bus.id_wd} : '0;
    always_ff @(posedge clk)
        if (rst || bus.flush || ((bus.stall_id || stallreq) && !bus.stall_ex)) q <= '0;
        else if (!bus.stall_ex) q <= d;
    assign bus.ex_valid  = q.valid;
    assign bus.ex_aluop  = q.aluop;
    assign bus.ex_alusel = q.alusel;
    assign bus.ex_reg1   = q.reg1;
    assign bus.ex_reg2   = q.reg2;
    assign bus.ex_wreg   = q.wreg;
    assign bus.ex_wd     = q.wd;
endmodule

// File: tb/tb_id_operand_fetch.sv
// tb_id_operand_fetch: directed vectors against hand-computed results for id_operand_fetch.
module tb_id_operand_fetch;
    logic clk = 1'b0;
    logic rst;
    int   vecs = 0, fails = 0;
    id_operand_fetch_if bus ();
    id_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_re1 = 0; bus.id_re2 = 0; bus.id_use_imm = 0;
        bus.id_raddr1 = 0; bus.id_raddr2 = 0; bus.id_imm = 0;
        bus.id_aluop = 0; bus.id_alusel = 0; bus.id_wreg = 0; bus.id_wd = 0;
        bus.rdata1 = 0; bus.rdata2 = 0;
        bus.ex_fwd_wreg = 0; bus.ex_fwd_wd = 0; bus.ex_fwd_wdata = 0; bus.ex_fwd_is_load = 0;
        bus.mem_fwd_wreg = 0; bus.mem_fwd_wd = 0; bus.mem_fwd_wdata = 0;
        bus.stall_id = 0; bus.stall_ex = 0; bus.flush = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        chk("reset stallreq", 32'(bus.stallreq), 0);
        chk("reset ex_valid", 32'(bus.ex_valid), 0);
        chk("reset ex_reg1", bus.ex_reg1, 0);
        rst = 0;
        // Plain read of r3
        bus.id_valid = 1; bus.id_re1 = 1; bus.id_raddr1 = 3; bus.rdata1 = 32'h0000_00AA;
        bus.id_aluop = 8'h21; bus.id_alusel = 3'd4; bus.id_wreg = 1; bus.id_wd = 5'd4;
        #1;
        chk("plain re1", 32'(bus.re1), 1);
        chk("plain raddr1", 32'(bus.raddr1), 3);
        tick();
        chk("plain ex_reg1", bus.ex_reg1, 32'h0000_00AA);
        chk("plain ex_valid", 32'(bus.ex_valid), 1);
        chk("plain ex_aluop", 32'(bus.ex_aluop), 32'h21);
        chk("plain ex_alusel", 32'(bus.ex_alusel), 4);
        chk("plain ex_wd", 32'(bus.ex_wd), 4);
        chk("plain ex_reg2 disabled", bus.ex_reg2, 0);
        // EX and MEM both hold r5; EX wins on both ports
        bus.id_re2 = 1; bus.id_raddr1 = 5; bus.id_raddr2 = 5; bus.rdata2 = 32'h3333_3333;
        bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 5; bus.ex_fwd_wdata = 32'h1111_1111;
        bus.mem_fwd_wreg = 1; bus.mem_fwd_wd = 5; bus.mem_fwd_wdata = 32'h2222_2222;
        tick();
        chk("dual ex_reg1", bus.ex_reg1, 32'h1111_1111);
        chk("dual ex_reg2", bus.ex_reg2, 32'h1111_1111);
        bus.ex_fwd_wreg = 0;
        tick();
        chk("mem fwd ex_reg1", bus.ex_reg1, 32'h2222_2222);
        // r0 never forwards
        bus.id_raddr1 = 0; bus.rdata1 = 32'h0000_1234;
        bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 0; bus.ex_fwd_wdata = 32'hFFFF_FFFF;
        bus.mem_fwd_wd = 0;
        tick();
        chk("r0 ex_reg1", bus.ex_reg1, 0);
        // Load-use on port 2
        idle();
        bus.id_valid = 1; bus.id_re2 = 1; bus.id_raddr2 = 7; bus.rdata2 = 32'h0BAD_0BAD;
        bus.id_wreg = 1; bus.id_wd = 5'd8;
        bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 7; bus.ex_fwd_is_load = 1; bus.ex_fwd_wdata = 32'h5555_5555;
        #1;
        chk("loaduse stallreq", 32'(bus.stallreq), 1);
        tick();
        chk("loaduse bubble valid", 32'(bus.ex_valid), 0);
        chk("loaduse bubble wreg", 32'(bus.ex_wreg), 0);
        bus.ex_fwd_wreg = 0; bus.ex_fwd_is_load = 0;
        bus.mem_fwd_wreg = 1; bus.mem_fwd_wd = 7; bus.mem_fwd_wdata = 32'hDEAD_BEEF;
        #1;
        chk("loaduse release", 32'(bus.stallreq), 0);
        tick();
        chk("loaduse ex_reg2", bus.ex_reg2, 32'hDEAD_BEEF);
        chk("loaduse ex_valid", 32'(bus.ex_valid), 1);
        // Immediate operand hides a load match on raddr2
        idle();
        bus.id_valid = 1; bus.id_re2 = 1; bus.id_use_imm = 1; bus.id_imm = 32'h0000_FFFF;
        bus.id_raddr2 = 9; bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 9; bus.ex_fwd_is_load = 1;
        #1;
        chk("imm re2", 32'(bus.re2), 0);
        chk("imm stallreq", 32'(bus.stallreq), 0);
        tick();
        chk("imm ex_reg2", bus.ex_reg2, 32'h0000_FFFF);
        // Flush beats stall_ex
        bus.flush = 1; bus.stall_ex = 1;
        tick();
        chk("flush ex_valid", 32'(bus.ex_valid), 0);
        chk("flush ex_reg2", bus.ex_reg2, 0);
        // Capture a known instruction, then hold it for three stall_ex cycles
        idle();
        bus.id_valid = 1; bus.id_re1 = 1; bus.id_raddr1 = 3; bus.rdata1 = 32'h0000_00AA;
        bus.id_use_imm = 1; bus.id_imm = 32'h0000_0042; bus.id_aluop = 8'h11; bus.id_wreg = 1; bus.id_wd = 5'd2;
        tick();
        chk("pre-hold ex_reg1", bus.ex_reg1, 32'h0000_00AA);
        bus.stall_ex = 1; bus.rdata1 = 32'h9999_9999; bus.id_imm = 32'h7777_7777; bus.id_aluop = 8'h33;
        for (int i = 0; i < 3; i++) begin
            bus.stall_id = (i == 1);
            tick();
            chk("hold ex_reg1", bus.ex_reg1, 32'h0000_00AA);
            chk("hold ex_reg2", bus.ex_reg2, 32'h0000_0042);
            chk("hold ex_aluop", 32'(bus.ex_aluop), 32'h11);
            chk("hold ex_valid", 32'(bus.ex_valid), 1);
        end
        // stall_id alone inserts a bubble
        bus.stall_ex = 0; bus.stall_id = 1;
        tick();
        chk("stall_id bubble", 32'(bus.ex_valid), 0);
        chk("stall_id reg1", bus.ex_reg1, 0);
        // Capture again, then reset during a load-use stall with stall_ex held
        bus.stall_id = 0;
        tick();
        chk("recapture ex_reg1", bus.ex_reg1, 32'h9999_9999);
        bus.id_use_imm = 0; bus.id_re2 = 1; bus.id_raddr2 = 6;
        bus.ex_fwd_wreg = 1; bus.ex_fwd_wd = 6; bus.ex_fwd_is_load = 1; bus.stall_ex = 1;
        #1;
        chk("pre-rst stallreq", 32'(bus.stallreq), 1);
        rst = 1;
        #1;
        chk("rst stallreq", 32'(bus.stallreq), 0);
        tick();
        chk("rst ex_valid", 32'(bus.ex_valid), 0);
        chk("rst ex_reg1", bus.ex_reg1, 0);
        chk("rst ex_wd", 32'(bus.ex_wd), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Register-file reader for the ID stage. It drives the read ports of the 32x32 register file from decoded instruction fields.
- It resolves RAW hazards against the EX and MEM stages by forwarding, and raises a stall request on load-use hazards.
- It holds the ID/EX pipeline register, with stall and flush control from the pipeline controller.
- It sits between the decoder and the EX stage; its outputs feed the ALU directly.

Parameters:
- DATA_W, 32, register/operand width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus)
- ALUOP_W, 8, ALU opcode width
- ALUSEL_W, 3, ALU result-select width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset (RstEnable = 1)
- id_valid  in  1  decoder presents an instruction this cycle
- id_re1, id_re2  in  1 each  operand 1/2 needs a register read
- id_raddr1, id_raddr2  in  ADDR_W each  source register addresses
- id_use_imm  in  1  operand 2 comes from id_imm instead of the register
- id_imm  in  DATA_W  extended immediate
- id_aluop  in  ALUOP_W  ALU opcode
- id_alusel  in  ALUSEL_W  ALU result select
- id_wreg  in  1  instruction writes a destination register
- id_wd  in  ADDR_W  destination register address
- re1, re2  out  1 each  regfile read enables
- raddr1, raddr2  out  ADDR_W each  regfile read addresses
- rdata1, rdata2  in  DATA_W each  regfile read data (combinational; already bypasses WB)
- ex_fwd_wreg  in  1  EX stage writes a register
- ex_fwd_wd  in  ADDR_W  EX stage destination
- ex_fwd_wdata  in  DATA_W  EX stage result
- ex_fwd_is_load  in  1  EX instruction is a load (result not yet available)
- mem_fwd_wreg  in  1  MEM stage writes a register
- mem_fwd_wd  in  ADDR_W  MEM stage destination
- mem_fwd_wdata  in  DATA_W  MEM stage result
- stall_id  in  1  controller holds the ID stage
- stall_ex  in  1  controller holds the EX stage
- flush  in  1  controller squashes the ID/EX contents
- stallreq  out  1  load-use stall request to the controller
- ex_valid  out  1  registered instruction valid
- ex_aluop  out  ALUOP_W  registered ALU opcode
- ex_alusel  out  ALUSEL_W  registered ALU result select
- ex_reg1  out  DATA_W  registered operand 1
- ex_reg2  out  DATA_W  registered operand 2
- ex_wreg  out  1  registered register-write enable
- ex_wd  out  ADDR_W  registered destination address

Behaviour:
- Read ports: combinational pass-through.
  - re1 = id_valid & id_re1.
  - re2 = id_valid & id_re2 & ~id_use_imm.
  - raddr1/raddr2 = id_raddr1/id_raddr2.
- Operand resolution (combinational, per operand):
  - Port not enabled -> 0. Exception: operand 2 with id_use_imm -> id_imm.
  - raddr == 0 -> 0, regardless of any forwarding source.
  - EX match (ex_fwd_wreg, ex_fwd_wd == raddr, not a load) -> ex_fwd_wdata.
  - Else MEM match -> mem_fwd_wdata.
  - Else rdata.
  - Priority is EX over MEM over regfile. Both operands may forward from the same source.
- stallreq = ~rst & id_valid & ex_fwd_is_load & ex_fwd_wreg & (ex_fwd_wd != 0) & (EX address match on any enabled port).
  - A match on a disabled port does not stall.
- ID/EX register update, evaluated in priority order at the rising edge:
  1. rst -> all outputs 0.
  2. flush -> bubble: all outputs 0.
  3. (stall_id | stallreq) & ~stall_ex -> bubble.
  4. stall_ex -> hold all outputs.
  5. Otherwise -> capture the resolved operands and the id_* control fields. ex_valid = id_valid.
- When id_valid = 0 on capture, the bubble fields are 0 (NOP).
- Latency: one cycle from ID inputs to ex_* outputs. There is no internal FSM beyond the register.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM, so the operand comes from the MEM forward.
- Reset mid-stall: stallreq deasserts in the same cycle as rst, and all registers read 0 after the edge.

Decomposition:
- The shared include define.v holds RegBus, RegAddrBus, ZeroWord, RstEnable, WriteEnable, ReadEnable, and the AluOpBus/AluSelBus widths with their NOP encodings (all 0).
- Sub-module: operand_fwd_mux, instantiated twice. It takes an address, enable, regfile data and both forward sources, and returns the resolved operand plus an EX-load-match flag.

Test Plan:
- Plain read: r3 = 0x0000_00AA in the regfile, id_raddr1 = 3, no forwards -> re1 = 1, raddr1 = 3, ex_reg1 = 0x0000_00AA one cycle later.
- Dual forward: EX writes r5 = 0x1111_1111 and MEM writes r5 = 0x2222_2222. An instruction reads r5 on both ports -> ex_reg1 = ex_reg2 = 0x1111_1111.
- r0 guard: EX forwards wd = 0 with data 0xFFFF_FFFF, and the instruction reads r0 -> ex_reg1 = 0.
- Load-use:
  - Stimulus: EX is a load to r7 and ID reads r7 on port 2.
  - Cycle 1: stallreq = 1 and ID/EX becomes a bubble (ex_valid = 0, ex_wreg = 0).
  - Cycle 2: with the load in MEM and mem_fwd_wdata = 0xDEAD_BEEF, stallreq = 0 and ex_reg2 = 0xDEAD_BEEF.
- Immediate and disabled port: id_use_imm = 1, id_imm = 0x0000_FFFF, EX is a load to the address on raddr2 -> re2 = 0, stallreq = 0, ex_reg2 = 0x0000_FFFF.
- Control priority:
  - flush together with stall_ex -> outputs 0.
  - stall_ex alone for 3 cycles -> outputs unchanged.
  - rst asserted during a stall -> all outputs 0 and stallreq = 0.
